// File: rtl/fifo_arb_pkg.sv
// Shared encodings for the two-producer FIFO write arbiter.
// State constants and one-hot grant values used by the arbiter and the bench.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_REQ0 = 2'b01;
    localparam logic [1:0] GRANT_REQ1 = 2'b10;

    function automatic state_t gnt_state(input logic who);
        return who ? ST_GNT1 : ST_GNT0;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Small synchronous FIFO with first-word fall-through read data.
// rdata always shows the oldest stored word; r_en pops it.
module fifo_sync #(
    parameter int MEMORY_WIDTH = 4,
    parameter int MEMORY_DEPTH = 4,
    parameter int ADDRESS_SIZE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic [MEMORY_WIDTH-1:0] wdata,
    input  logic                    r_en,
    output logic [MEMORY_WIDTH-1:0] rdata,
    output logic                    full,
    output logic                    empty
);

    localparam logic [ADDRESS_SIZE:0] DEPTH_CNT =
        (ADDRESS_SIZE+1)'(MEMORY_DEPTH);

    logic [MEMORY_WIDTH-1:0] mem_q [MEMORY_DEPTH];
    logic [ADDRESS_SIZE-1:0] wptr_q, wptr_d;
    logic [ADDRESS_SIZE-1:0] rptr_q, rptr_d;
    logic [ADDRESS_SIZE:0]   count_q, count_d;
    logic                    do_wr, do_rd;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign rdata = mem_q[rptr_q];
    assign do_wr = w_en & ~full;
    assign do_rd = r_en & ~empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_wr) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_rd) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a tie goes to the side that did not own last.
// Pure combinational; winner is meaningless when any_valid is low.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       winner,
    output logic       any_valid
);

    always_comb begin
        any_valid = |valid;
        winner    = 1'b0;
        unique case (1'b1)
            (valid == 2'b11): winner = ~last_grant;
            (valid == 2'b10): winner = 1'b1;
            default:          winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo_sync write port between two
// producers; fifo_full stalls the current owner without losing its grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int MEMORY_WIDTH = 4,
    parameter int BURST_LEN    = 2,
    parameter int CNT_SIZE     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    input  logic [MEMORY_WIDTH-1:0] req0_data,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [MEMORY_WIDTH-1:0] req1_data,
    output logic                    req1_ready,
    input  logic                    fifo_full,
    output logic                    fifo_w_en,
    output logic [MEMORY_WIDTH-1:0] fifo_wdata,
    output logic [1:0]              grant
);

    localparam logic [CNT_SIZE-1:0] LAST_BEAT = CNT_SIZE'(BURST_LEN - 1);

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [CNT_SIZE-1:0] beat_cnt_q, beat_cnt_d;

    logic owner;
    logic own_valid;
    logic other_valid;
    logic accept;
    logic pick;
    logic any_valid;

    rr_pick2 u_pick (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .winner     (pick),
        .any_valid  (any_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        owner        = 1'b0;
        own_valid    = 1'b0;
        other_valid  = 1'b0;
        accept       = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        fifo_w_en    = 1'b0;
        fifo_wdata   = '0;
        grant        = GRANT_NONE;
        unique case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d = gnt_state(pick);
                end
            end
            ST_GNT0, ST_GNT1: begin
                owner       = (state_q == ST_GNT1);
                own_valid   = owner ? req1_valid : req0_valid;
                other_valid = owner ? req0_valid : req1_valid;
                // A word must never reach the FIFO in a reset cycle.
                accept      = own_valid & ~fifo_full & ~rst;
                req0_ready  = ~owner & ~fifo_full & ~rst;
                req1_ready  = owner & ~fifo_full & ~rst;
                fifo_w_en   = accept;
                if (!rst) begin
                    grant      = owner ? GRANT_REQ1 : GRANT_REQ0;
                    fifo_wdata = owner ? req1_data : req0_data;
                end
                if (!own_valid || (accept && beat_cnt_q == LAST_BEAT)) begin
                    last_grant_d = owner;
                    beat_cnt_d   = '0;
                    if (other_valid) begin
                        state_d = gnt_state(~owner);
                    end else if (own_valid) begin
                        state_d = gnt_state(owner);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_SIZE'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: arbiter in front of a 4-deep fifo_sync, checking grants,
// write order, backpressure, early release and mid-burst reset.
module tb_fifo_wr_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       fifo_full, fifo_empty;
    logic       fifo_w_en, r_en;
    logic [3:0] fifo_wdata, rdata;
    logic [1:0] grant;

    int total = 0;
    int bad   = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] wlog[$];
    logic [3:0] rlog[$];

    fifo_wr_arbiter #(
        .MEMORY_WIDTH (4),
        .BURST_LEN    (2),
        .CNT_SIZE     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .fifo_full  (fifo_full),
        .fifo_w_en  (fifo_w_en),
        .fifo_wdata (fifo_wdata),
        .grant      (grant)
    );

    fifo_sync #(
        .MEMORY_WIDTH (4),
        .MEMORY_DEPTH (4),
        .ADDRESS_SIZE (2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .w_en  (fifo_w_en),
        .wdata (fifo_wdata),
        .r_en  (r_en),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_w_en) wlog.push_back(fifo_wdata);
        if (r_en && !fifo_empty) rlog.push_back(rdata);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        req0_valid = (q0.size() != 0);
        req0_data  = req0_valid ? q0[0] : 4'h0;
        req1_valid = (q1.size() != 0);
        req1_data  = req1_valid ? q1[0] : 4'h0;
    endtask

    // One clock: note handshakes before the edge, advance producers after.
    task automatic step();
        logic a0, a1;
        #1;
        a0 = req0_valid & req0_ready;
        a1 = req1_valid & req1_ready;
        @(posedge clk);
        #1;
        if (a0 && q0.size() != 0) void'(q0.pop_front());
        if (a1 && q1.size() != 0) void'(q1.pop_front());
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        r_en = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        step();
        step();
        wlog.delete();
        rlog.delete();
        rst = 1'b0;
        #1;
    endtask

    logic [3:0] exp_w [8];
    logic [1:0] exp_g [8];

    initial begin
        exp_w = '{4'hA, 4'hB, 4'h5, 4'h6, 4'hC, 4'hD, 4'h7, 4'h8};
        exp_g = '{2'b01, 2'b01, 2'b10, 2'b10,
                  2'b01, 2'b01, 2'b10, 2'b10};
        rst  = 1'b1;
        r_en = 1'b0;
        drive();
        step();
        check("rst_grant", grant, 2'b00);
        check("rst_wen", fifo_w_en, 1'b0);
        check("rst_rdy0", req0_ready, 1'b0);
        check("rst_wdata", fifo_wdata, 4'h0);

        // single producer, burst boundary re-grant
        do_reset();
        q0 = '{4'h1, 4'h2, 4'h3};
        drive();
        #1;
        check("t1_c0_grant", grant, 2'b00);
        step();
        check("t1_c1_grant", grant, 2'b01);
        check("t1_c1_wdata", fifo_wdata, 4'h1);
        step();
        check("t1_c2_wdata", fifo_wdata, 4'h2);
        step();
        check("t1_c3_grant", grant, 2'b01);
        check("t1_c3_wen", fifo_w_en, 1'b1);
        check("t1_c3_wdata", fifo_wdata, 4'h3);
        check("t1_c3_cnt", dut.beat_cnt_q, 2'd0);
        step();
        check("t1_c4_wen", fifo_w_en, 1'b0);
        check("t1_nwr", wlog.size(), 3);
        step();
        check("t1_idle", grant, 2'b00);
        r_en = 1'b1;
        #1;
        check("t1_rd0", rdata, 4'h1);
        step();
        check("t1_rd1", rdata, 4'h2);
        step();
        check("t1_rd2", rdata, 4'h3);
        step();
        r_en = 1'b0;
        #1;
        check("t1_empty", fifo_empty, 1'b1);

        // contention with a draining reader
        do_reset();
        r_en = 1'b1;
        q0 = '{4'hA, 4'hB, 4'hC, 4'hD};
        q1 = '{4'h5, 4'h6, 4'h7, 4'h8};
        drive();
        #1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("t2_g%0d", i), grant, exp_g[i]);
        end
        step();
        step();
        step();
        check("t2_nwr", wlog.size(), 8);
        check("t2_nrd", rlog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_w%0d", i),
                  (i < wlog.size()) ? wlog[i] : 4'hF, exp_w[i]);
            check($sformatf("t2_r%0d", i),
                  (i < rlog.size()) ? rlog[i] : 4'hF, exp_w[i]);
        end
        r_en = 1'b0;

        // backpressure with req1 mid-burst
        do_reset();
        q0 = '{4'h1, 4'h2, 4'h3};
        drive();
        #1;
        step();
        step();
        step();
        q1 = '{4'h5, 4'h6};
        drive();
        #1;
        step();
        step();
        check("t3_c5_wdata", fifo_wdata, 4'h5);
        step();
        q0 = '{4'h7};
        drive();
        #1;
        check("t3_full", fifo_full, 1'b1);
        check("t3_cnt", dut.beat_cnt_q, 2'd1);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            check($sformatf("t3_rdy%0d", i), req1_ready, 1'b0);
            check($sformatf("t3_wen%0d", i), fifo_w_en, 1'b0);
            check($sformatf("t3_g%0d", i), grant, 2'b10);
        end
        step();
        r_en = 1'b1;
        #1;
        check("t3_rd", rdata, 4'h1);
        check("t3_c9_wen", fifo_w_en, 1'b0);
        step();
        r_en = 1'b0;
        #1;
        check("t3_c10_wen", fifo_w_en, 1'b1);
        check("t3_c10_wdata", fifo_wdata, 4'h6);
        step();
        check("t3_c11_grant", grant, 2'b01);
        check("t3_c11_wen", fifo_w_en, 1'b0);
        check("t3_nwr", wlog.size(), 5);

        // early release by dropping valid
        do_reset();
        q0 = '{4'h9};
        q1 = '{4'h4};
        drive();
        #1;
        step();
        check("t4_c1_grant", grant, 2'b01);
        check("t4_c1_wdata", fifo_wdata, 4'h9);
        step();
        check("t4_c2_grant", grant, 2'b01);
        check("t4_c2_wen", fifo_w_en, 1'b0);
        step();
        check("t4_c3_grant", grant, 2'b10);
        check("t4_c3_cnt", dut.beat_cnt_q, 2'd0);
        check("t4_c3_wdata", fifo_wdata, 4'h4);

        // reset in the middle of a req1 burst
        do_reset();
        q1 = '{4'h1, 4'h2, 4'h3};
        drive();
        #1;
        step();
        check("t5_c1_grant", grant, 2'b10);
        step();
        check("t5_c2_cnt", dut.beat_cnt_q, 2'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_wen", fifo_w_en, 1'b0);
        check("t5_rst_rdy", req1_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("t5_post_grant", grant, 2'b00);
        check("t5_post_wen", fifo_w_en, 1'b0);
        check("t5_nwr", wlog.size(), 1);
        q0 = '{4'hE};
        drive();
        #1;
        step();
        check("t5_tie_grant", grant, 2'b01);
        check("t5_tie_wdata", fifo_wdata, 4'hE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that lets two producers share the single write port of one fifo_sync instance.
- Grants one producer at a time for a burst of up to BURST_LEN accepted words.
- Drives the FIFO's w_en/wdata and honours its full flag as backpressure.
- Sits directly in front of fifo_sync; the read side of the FIFO is untouched.

Parameters:
- MEMORY_WIDTH, 4, data word width; must match the fifo_sync instance.
- BURST_LEN, 2, maximum accepted words per grant (1..2^CNT_SIZE-1).
- CNT_SIZE, 2, width of the beat counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  producer 0 has a word.
- req0_data  in  MEMORY_WIDTH  producer 0 word.
- req0_ready  out  1  producer 0 word accepted this cycle (valid & ready).
- req1_valid  in  1  producer 1 has a word.
- req1_data  in  MEMORY_WIDTH  producer 1 word.
- req1_ready  out  1  producer 1 word accepted this cycle.
- fifo_full  in  1  full flag from fifo_sync.
- fifo_w_en  out  1  to fifo_sync w_en.
- fifo_wdata  out  MEMORY_WIDTH  to fifo_sync wdata.
- grant  out  2  one-hot current owner; 2'b00 when idle.

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is rst.
- Reset state: state=IDLE, last_grant=1 (so req0 wins the first tie), beat_cnt=0, grant=00.
- Reset forces req*_ready=0, fifo_w_en=0 and fifo_wdata=0.
- Reset mid-burst abandons the burst. No partial word is written in the reset cycle: fifo_w_en is gated by !rst.
- State machine: IDLE, GNT0, GNT1. State, last_grant and beat_cnt are registered. Ready, w_en, wdata and grant decode combinationally from the registered state.
- IDLE:
  - no valid -> stay.
  - one valid -> GNTx.
  - both valid -> grant the requester != last_grant.
  - Arbitration costs one cycle: no write happens in IDLE.
- GNTx:
  - reqx_ready = !fifo_full.
  - fifo_w_en = reqx_valid & !fifo_full.
  - fifo_wdata = reqx_data. It is 0 outside a grant.
  - Other requester ready = 0.
- Accepted beat: fifo_w_en=1. It increments beat_cnt.
- Grant release, either case sets last_grant=x and clears beat_cnt:
  - (a) accepted beat with beat_cnt==BURST_LEN-1, or
  - (b) reqx_valid=0 in GNTx.
- Next state after release: the other requester's GNT if its valid is high that cycle (no bubble), else IDLE.
  - If only x is still valid after a full burst, GNTx is re-entered directly. last_grant is updated, but there is no other contender, so no starvation.
- fifo_full while granted:
  - Stall: grant held, beat_cnt held, no write.
  - No timeout. The other requester waits.
- fifo_full in IDLE: arbitration still proceeds; the stall simply occurs in GNTx.
- Producer contract: reqx_valid/data stay stable until ready. Dropping valid releases the grant per (b).
- Words from one producer keep their order in the FIFO; ordering between producers follows grant order.
- Throughput: 1 word/cycle while granted and not full.

Decomposition:
- Package fifo_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2;
  - the grant one-hot constants.
- One natural sub-module, rr_pick2: a combinational two-way round-robin picker (valids + last_grant -> winner, any_valid).
- The FSM, beat counter and muxing stay in fifo_wr_arbiter.
- The bench instantiates fifo_wr_arbiter + fifo_sync (MEMORY_DEPTH=4, ADDRESS_SIZE=2) and checks rdata order.

Test Plan:
1. Single producer: req0 sends 1,2,3 back-to-back, req1 idle.
   - grant=01 from the cycle after valid.
   - FIFO holds 1,2,3 after 4 cycles.
   - The burst boundary after 2 re-grants req0 with no idle cycle.
   - Read-out gives 1,2,3.
2. Contention: both valid from reset release, req0 data A,B,C,D, req1 data 5,6,7,8.
   - FIFO write order is A,B,5,6,C,D,7,8.
   - grant goes 01,10,01,10, with no idle cycle between bursts.
3. Backpressure: fill the FIFO to 4 words (full=1) with req1 granted, beat_cnt=1.
   - req1_ready=0 and no w_en for 3 cycles; grant stays 10.
   - After one FIFO read, exactly 1 word is written and the grant passes to req0.
4. Early release: req0 sends 1 word, then drops valid, while req1 is valid.
   - grant switches 01->10 on the next cycle; beat_cnt=0.
5. Reset mid-burst: assert rst for 1 cycle while in GNT1 with beat_cnt=1.
   - Next cycle: grant=00, w_en=0.
   - Both then valid -> req0 granted first.
